// File: rtl/memory_responder.sv
// memory_responder - wait-stated word-addressed RAM behind the MAR/MDR memory interface
//
// Accepts one read or write request at a time from the datapath, waits
// WAIT_STATES cycles, performs the access on an internal RAM, then pulses
// mem_ready (with mem_err on a faulted request) for one cycle.
//
// Ports:
//   clock      in   rising-edge system clock
//   clear      in   synchronous active-high reset
//   mem_addr   in   word address from MAR
//   mem_read   in   read request (level)
//   mem_write  in   write request (level)
//   mem_wdata  in   write data from MDR
//   mem_rdata  out  read data to MDR, held until the next completed read
//   mem_ready  out  one-cycle completion pulse
//   mem_busy   out  high while a request is in flight
//   mem_err    out  one-cycle fault pulse coincident with mem_ready
module memory_responder #(
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_BITS   = 9,
    parameter int WAIT_STATES = 2
) (
    input  logic                  clock,
    input  logic                  clear,
    input  logic [31:0]           mem_addr,
    input  logic                  mem_read,
    input  logic                  mem_write,
    input  logic [DATA_WIDTH-1:0] mem_wdata,
    output logic [DATA_WIDTH-1:0] mem_rdata,
    output logic                  mem_ready,
    output logic                  mem_busy,
    output logic                  mem_err
);

    localparam int DEPTH = 2 ** ADDR_BITS;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_ACCESS,
        S_DONE
    } state_t;

    state_t                state_q, state_d;
    logic [3:0]            cnt_q, cnt_d;
    logic [ADDR_BITS-1:0]  addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic                  write_q, write_d;
    logic                  fault_q, fault_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic                  ready_q, busy_q, err_q;
    logic                  ram_we;

    logic [DATA_WIDTH-1:0] ram [DEPTH];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        write_d = write_q;
        fault_d = fault_q;
        rdata_d = rdata_q;
        unique case (state_q)
            S_IDLE: begin
                if (mem_read && mem_write) begin
                    // Conflicting strobes: nothing is latched, report straight away.
                    fault_d = 1'b1;
                    write_d = 1'b0;
                    state_d = S_DONE;
                end else if (mem_read ^ mem_write) begin
                    addr_d  = mem_addr[ADDR_BITS-1:0];
                    wdata_d = mem_wdata;
                    write_d = mem_write;
                    fault_d = |mem_addr[31:ADDR_BITS];
                    cnt_d   = 4'(WAIT_STATES);
                    state_d = (WAIT_STATES > 0) ? S_WAIT : S_ACCESS;
                end
            end
            S_WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q <= 4'd1) begin
                    state_d = S_ACCESS;
                end
            end
            S_ACCESS: begin
                if (!write_q) begin
                    // Out-of-range reads return zero rather than aliased RAM data.
                    rdata_d = fault_q ? '0 : ram[addr_q];
                end
                state_d = S_DONE;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Gating with clear guarantees a reset in the access cycle drops the write.
    assign ram_we = (state_q == S_ACCESS) && write_q && !fault_q && !clear;

    always_ff @(posedge clock) begin
        if (ram_we) begin
            ram[addr_q] <= wdata_q;
        end
    end

    // Outputs are registered from the next state so they line up exactly
    // with the state they describe.
    always_ff @(posedge clock) begin
        if (clear) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            write_q <= 1'b0;
            fault_q <= 1'b0;
            rdata_q <= '0;
            ready_q <= 1'b0;
            busy_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            write_q <= write_d;
            fault_q <= fault_d;
            rdata_q <= rdata_d;
            ready_q <= (state_d == S_DONE);
            busy_q  <= (state_d != S_IDLE);
            err_q   <= (state_d == S_DONE) && fault_d;
        end
    end

    assign mem_rdata = rdata_q;
    assign mem_ready = ready_q;
    assign mem_busy  = busy_q;
    assign mem_err   = err_q;

endmodule

// File: tb/tb_memory_responder.sv
// tb/tb_memory_responder.sv - self-checking bench for memory_responder
module tb_memory_responder;

    logic        clock = 1'b0;
    logic        clear = 1'b1;
    logic        rd_s    [2];
    logic        wr_s    [2];
    logic [31:0] addr_s  [2];
    logic [31:0] wd_s    [2];
    logic [31:0] rdata_s [2];
    logic        rdy_s   [2];
    logic        busy_s  [2];
    logic        err_s   [2];

    int checks   = 0;
    int failures = 0;

    typedef struct {
        int          u;
        logic        rd;
        logic        wr;
        logic [31:0] a;
        logic [31:0] wd;
        logic [31:0] er;
        logic        ee;
        int          el;
    } vec_t;

    typedef struct {
        logic [31:0] er;
        logic        ee;
        int          el;
    } exp_t;

    vec_t vecs [17];
    exp_t sb [$];

    always #5 clock = ~clock;

    memory_responder #(.DATA_WIDTH(32), .ADDR_BITS(9), .WAIT_STATES(2)) dut_ws2 (
        .clock(clock), .clear(clear), .mem_addr(addr_s[0]), .mem_read(rd_s[0]),
        .mem_write(wr_s[0]), .mem_wdata(wd_s[0]), .mem_rdata(rdata_s[0]),
        .mem_ready(rdy_s[0]), .mem_busy(busy_s[0]), .mem_err(err_s[0])
    );

    memory_responder #(.DATA_WIDTH(32), .ADDR_BITS(9), .WAIT_STATES(0)) dut_ws0 (
        .clock(clock), .clear(clear), .mem_addr(addr_s[1]), .mem_read(rd_s[1]),
        .mem_write(wr_s[1]), .mem_wdata(wd_s[1]), .mem_rdata(rdata_s[1]),
        .mem_ready(rdy_s[1]), .mem_busy(busy_s[1]), .mem_err(err_s[1])
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%08h required=0x%08h", nm, act, exp);
        end
    endtask

    // Drive one request, then change the inputs right after acceptance so
    // any failure to latch shows up. Latency counts edges from the sample
    // edge to the edge that captures mem_ready.
    task automatic run_req(input int u, input logic rd, input logic wr,
                           input logic [31:0] a, input logic [31:0] wd,
                           input logic [31:0] er, input logic ee, input int el,
                           input int idx);
        exp_t e;
        int   k;
        logic seen;
        sb.push_back('{er: er, ee: ee, el: el});
        @(negedge clock);
        rd_s[u] = rd; wr_s[u] = wr; addr_s[u] = a; wd_s[u] = wd;
        @(posedge clock);
        #1;
        rd_s[u] = 1'b0; wr_s[u] = 1'b0; addr_s[u] = 32'h2; wd_s[u] = 32'h0;
        chk($sformatf("v%0d_busy", idx), {31'b0, busy_s[u]}, 32'h1);
        k = 0;
        seen = 1'b0;
        while (k < 40 && !seen) begin
            if (rdy_s[u]) begin
                seen = 1'b1;
            end else begin
                @(posedge clock);
                #1;
                k++;
            end
        end
        if (!seen) begin
            checks++;
            failures++;
            $display("FAIL v%0d_timeout actual=no_ready required=ready", idx);
            void'(sb.pop_front());
        end else begin
            e = sb.pop_front();
            chk($sformatf("v%0d_latency", idx), 32'(k + 1), 32'(e.el));
            chk($sformatf("v%0d_rdata", idx), rdata_s[u], e.er);
            chk($sformatf("v%0d_err", idx), {31'b0, err_s[u]}, {31'b0, e.ee});
            @(posedge clock);
            #1;
            chk($sformatf("v%0d_ready_pulse", idx), {31'b0, rdy_s[u]}, 32'h0);
            chk($sformatf("v%0d_idle_busy", idx), {31'b0, busy_s[u]}, 32'h0);
        end
    endtask

    initial begin
        int pulses;
        for (int i = 0; i < 2; i++) begin
            rd_s[i] = 1'b0; wr_s[i] = 1'b0; addr_s[i] = '0; wd_s[i] = '0;
        end

        //               u  rd    wr    addr          wdata         exp rdata     err   lat
        vecs[0]  = '{0, 1'b0, 1'b1, 32'h0000_0000, 32'h0BAD_F00D, 32'h0000_0000, 1'b0, 4};
        vecs[1]  = '{0, 1'b0, 1'b1, 32'h0000_0002, 32'hAAAA_0002, 32'h0000_0000, 1'b0, 4};
        vecs[2]  = '{0, 1'b0, 1'b1, 32'h0000_0005, 32'h1111_1105, 32'h0000_0000, 1'b0, 4};
        vecs[3]  = '{0, 1'b0, 1'b1, 32'h0000_001F, 32'hDEAD_BEEF, 32'h0000_0000, 1'b0, 4};
        vecs[4]  = '{0, 1'b1, 1'b0, 32'h0000_001F, 32'h0000_0000, 32'hDEAD_BEEF, 1'b0, 4};
        vecs[5]  = '{0, 1'b0, 1'b1, 32'h0000_0003, 32'h0000_0055, 32'hDEAD_BEEF, 1'b0, 4};
        vecs[6]  = '{0, 1'b1, 1'b0, 32'h0000_0003, 32'h0000_0000, 32'h0000_0055, 1'b0, 4};
        vecs[7]  = '{0, 1'b1, 1'b0, 32'h0000_0002, 32'h0000_0000, 32'hAAAA_0002, 1'b0, 4};
        vecs[8]  = '{0, 1'b1, 1'b0, 32'h0000_0200, 32'h0000_0000, 32'h0000_0000, 1'b1, 4};
        vecs[9]  = '{0, 1'b0, 1'b1, 32'h0000_0200, 32'h0000_0077, 32'h0000_0000, 1'b1, 4};
        vecs[10] = '{0, 1'b1, 1'b1, 32'h0000_0002, 32'h0000_FFFF, 32'h0000_0000, 1'b1, 1};
        vecs[11] = '{0, 1'b1, 1'b0, 32'h0000_0000, 32'h0000_0000, 32'h0BAD_F00D, 1'b0, 4};
        vecs[12] = '{0, 1'b1, 1'b0, 32'h0000_0002, 32'h0000_0000, 32'hAAAA_0002, 1'b0, 4};
        vecs[13] = '{0, 1'b1, 1'b0, 32'h8000_001F, 32'h0000_0000, 32'h0000_0000, 1'b1, 4};
        vecs[14] = '{1, 1'b0, 1'b1, 32'h0000_0007, 32'h0000_005A, 32'h0000_0000, 1'b0, 2};
        vecs[15] = '{1, 1'b1, 1'b0, 32'h0000_0007, 32'h0000_0000, 32'h0000_005A, 1'b0, 2};
        vecs[16] = '{1, 1'b1, 1'b1, 32'h0000_0007, 32'h0000_0001, 32'h0000_005A, 1'b1, 1};

        clear = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        clear = 1'b0;
        for (int u = 0; u < 2; u++) begin
            chk($sformatf("reset_rdata_u%0d", u), rdata_s[u], 32'h0);
            chk($sformatf("reset_ready_u%0d", u), {31'b0, rdy_s[u]}, 32'h0);
            chk($sformatf("reset_busy_u%0d", u), {31'b0, busy_s[u]}, 32'h0);
            chk($sformatf("reset_err_u%0d", u), {31'b0, err_s[u]}, 32'h0);
        end

        for (int i = 0; i < 17; i++) begin
            run_req(vecs[i].u, vecs[i].rd, vecs[i].wr, vecs[i].a, vecs[i].wd,
                    vecs[i].er, vecs[i].ee, vecs[i].el, i);
        end

        // A read held high through DONE is accepted again: two accesses in
        // the window, not one.
        @(negedge clock);
        rd_s[0] = 1'b1; addr_s[0] = 32'h3;
        pulses = 0;
        for (int c = 0; c < 15; c++) begin
            @(posedge clock);
            #1;
            if (c == 6) rd_s[0] = 1'b0;
            if (rdy_s[0]) pulses++;
        end
        chk("held_read_pulses", 32'(pulses), 32'd2);
        chk("held_read_rdata", rdata_s[0], 32'h0000_0055);

        // Reset during WAIT of a write: no ready, RAM untouched.
        @(negedge clock);
        wr_s[0] = 1'b1; addr_s[0] = 32'h5; wd_s[0] = 32'h1234;
        @(posedge clock);
        #1;
        wr_s[0] = 1'b0; addr_s[0] = 32'h2; wd_s[0] = 32'h0;
        @(posedge clock);
        #1;
        chk("midrst_in_wait_busy", {31'b0, busy_s[0]}, 32'h1);
        clear = 1'b1;
        @(posedge clock);
        #1;
        clear = 1'b0;
        chk("midrst_busy", {31'b0, busy_s[0]}, 32'h0);
        chk("midrst_rdata", rdata_s[0], 32'h0);
        pulses = 0;
        for (int c = 0; c < 8; c++) begin
            @(posedge clock);
            #1;
            if (rdy_s[0]) pulses++;
        end
        chk("midrst_no_ready", 32'(pulses), 32'd0);
        run_req(0, 1'b1, 1'b0, 32'h5, 32'h0, 32'h1111_1105, 1'b0, 4, 100);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
